// File: rtl/anita3_scaler_snapshot.sv
`timescale 1ns/1ps
// ANITA-3 scaler snapshot engine.
// On each PPS rising edge, the block waits for the scaler bank to settle.
// It then sweeps the 36 scaler addresses and captures them into a
// ping-pong bank. Completed snapshots are served to the host through a
// registered read port.
module anita3_scaler_snapshot #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        pps_i,
    output logic [5:0]  scal_addr_o,
    input  logic [31:0] scal_dat_i,
    input  logic [5:0]  rd_addr_i,
    output logic [31:0] rd_dat_o,
    output logic        snap_done_o,
    output logic        snap_valid_o,
    output logic [15:0] snap_count_o,
    output logic        busy_o,
    output logic        overrun_o,
    input  logic        clr_overrun_i
);
    localparam int          NWORDS    = 36;
    localparam logic [5:0]  LAST_K    = 6'd36;   // extra sweep step for the final capture
    localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, SWEEP, SWAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic [5:0]  k_q, k_d;
    logic        pps_meta_q, pps_sync_q, pps_prev_q;
    logic        pps_rise;
    logic [5:0]  scal_addr_q, scal_addr_d;
    logic        cap_vld_q, cap_vld_d;
    logic [5:0]  cap_idx_q, cap_idx_d;
    logic [31:0] cap_dat_q, cap_dat_d;
    logic        wr_bank_q, wr_bank_d;
    logic        swap;
    logic [31:0] rd_dat_q, rd_dat_d;
    logic        snap_done_q, snap_done_d;
    logic        snap_valid_q, snap_valid_d;
    logic [15:0] snap_count_q, snap_count_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;

    logic [31:0] bank_q [2][NWORDS];

    // Scaler mux address for sweep step k: the last two words skip 0x22/0x23.
    function automatic logic [5:0] sweep_addr(input logic [5:0] k);
        return (k < 6'd34) ? k : k + 6'd2;
    endfunction

    assign pps_rise = pps_sync_q & ~pps_prev_q;
    assign swap     = (state_q == SWAP);

    // Next-state logic for the snapshot sequencer.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        k_d          = k_q;
        case (state_q)
            IDLE: begin
                if (pps_rise) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = SWEEP;
                        k_d     = '0;
                    end else begin
                        state_d      = SETTLE;
                        settle_cnt_d = SETTLE_LD;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_q <= 16'd1) begin
                    state_d = SWEEP;
                    k_d     = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q - 16'd1;
                end
            end
            SWEEP: begin
                if (k_q == LAST_K) state_d = SWAP;
                else               k_d     = k_q + 6'd1;
            end
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs, the capture pipeline and the bank selection.
    always_comb begin
        scal_addr_d  = (state_d == SWEEP && k_d < LAST_K) ? sweep_addr(k_d) : 6'h00;
        cap_vld_d    = (state_q == SWEEP) && (k_q != LAST_K);
        cap_idx_d    = k_q;
        cap_dat_d    = scal_dat_i;
        busy_d       = (state_d == SETTLE) || (state_d == SWEEP);
        snap_done_d  = (state_d == SWAP);
        wr_bank_d    = swap ? ~wr_bank_q : wr_bank_q;
        snap_valid_d = snap_valid_q | swap;
        snap_count_d = swap ? snap_count_q + 16'd1 : snap_count_q;
        // A PPS edge outside IDLE is dropped. If a clear arrives in the same cycle, the set takes priority.
        if (pps_rise && state_q != IDLE) overrun_d = 1'b1;
        else if (clr_overrun_i)          overrun_d = 1'b0;
        else                             overrun_d = overrun_q;
        // Reads use the bank that is not being filled. The bank toggle takes effect only after SWAP.
        if (snap_valid_q && rd_addr_i < LAST_K) rd_dat_d = bank_q[~wr_bank_q][rd_addr_i];
        else                                    rd_dat_d = 32'h0;
    end

    // Control state, PPS synchroniser and registered outputs with synchronous reset.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            k_q          <= '0;
            pps_meta_q   <= 1'b0;
            pps_sync_q   <= 1'b0;
            pps_prev_q   <= 1'b0;
            scal_addr_q  <= '0;
            cap_vld_q    <= 1'b0;
            cap_idx_q    <= '0;
            cap_dat_q    <= '0;
            wr_bank_q    <= 1'b0;
            rd_dat_q     <= '0;
            snap_done_q  <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_count_q <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            k_q          <= k_d;
            pps_meta_q   <= pps_i;
            pps_sync_q   <= pps_meta_q;
            pps_prev_q   <= pps_sync_q;
            scal_addr_q  <= scal_addr_d;
            cap_vld_q    <= cap_vld_d;
            cap_idx_q    <= cap_idx_d;
            cap_dat_q    <= cap_dat_d;
            wr_bank_q    <= wr_bank_d;
            rd_dat_q     <= rd_dat_d;
            snap_done_q  <= snap_done_d;
            snap_valid_q <= snap_valid_d;
            snap_count_q <= snap_count_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    // Bank write: the captured word lands in the fill bank one cycle after its address was driven.
    always_ff @(posedge clk33_i) begin
        if (cap_vld_q) bank_q[wr_bank_q][cap_idx_q] <= cap_dat_q;
    end

    assign scal_addr_o  = scal_addr_q;
    assign rd_dat_o     = rd_dat_q;
    assign snap_done_o  = snap_done_q;
    assign snap_valid_o = snap_valid_q;
    assign snap_count_o = snap_count_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_anita3_scaler_snapshot.sv
`timescale 1ns/1ps
// Directed bench for anita3_scaler_snapshot.
// The scaler model returns base ^ addr, so each snapshot can be told apart from the others.
module tb_anita3_scaler_snapshot;
    logic        clk33_i = 1'b0;
    logic        rst_i;
    logic        pps_i;
    logic [5:0]  scal_addr_o;
    logic [31:0] scal_dat_i;
    logic [5:0]  rd_addr_i;
    logic [31:0] rd_dat_o;
    logic        snap_done_o;
    logic        snap_valid_o;
    logic [15:0] snap_count_o;
    logic        busy_o;
    logic        overrun_o;
    logic        clr_overrun_i;
    logic [31:0] base;
    int          n_chk;
    int          n_pass;

    anita3_scaler_snapshot #(.SETTLE_CYCLES(4)) dut (
        .clk33_i       (clk33_i),
        .rst_i         (rst_i),
        .pps_i         (pps_i),
        .scal_addr_o   (scal_addr_o),
        .scal_dat_i    (scal_dat_i),
        .rd_addr_i     (rd_addr_i),
        .rd_dat_o      (rd_dat_o),
        .snap_done_o   (snap_done_o),
        .snap_valid_o  (snap_valid_o),
        .snap_count_o  (snap_count_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .clr_overrun_i (clr_overrun_i)
    );

    assign scal_dat_i = base ^ {26'h0, scal_addr_o};

    always #15 clk33_i = ~clk33_i;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk33_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Hand table of scaler mux addresses used by the sweep.
    function automatic logic [5:0] exp_addr(input int i);
        case (i)
            32:      return 6'h20;
            33:      return 6'h21;
            34:      return 6'h24;
            35:      return 6'h25;
            default: return 6'(i);
        endcase
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  {31'h0, busy_o}, 32'h0);
        chk({tag, "_addr"},  {26'h0, scal_addr_o}, 32'h0);
        chk({tag, "_done"},  {31'h0, snap_done_o}, 32'h0);
        chk({tag, "_valid"}, {31'h0, snap_valid_o}, 32'h0);
        chk({tag, "_count"}, {16'h0, snap_count_o}, 32'h0);
        chk({tag, "_rd"},    rd_dat_o, 32'h0);
        chk({tag, "_ovr"},   {31'h0, overrun_o}, 32'h0);
    endtask

    // One PPS-triggered snapshot, with rd_addr_i held at 5.
    // rd_old is the read value expected until the swap becomes visible.
    task automatic do_snap(input logic [31:0] b, input logic [31:0] rd_old, input logic [15:0] cnt_exp,
                           input bit ovr, input int rst_at, input bit ovr_exp);
        base = b; rd_addr_i = 6'd5; pps_i = 1'b1;
        tick(); tick();
        chk("busy_presync", {31'h0, busy_o}, 32'h0);
        tick();
        chk("busy_start", {31'h0, busy_o}, 32'h1);
        chk("rd_at_start", rd_dat_o, rd_old);
        for (int i = 0; i < 4; i++) begin
            chk("settle_addr", {26'h0, scal_addr_o}, 32'h0);
            tick();
        end
        for (int k = 0; k < 36; k++) begin
            chk("sweep_addr", {26'h0, scal_addr_o}, {26'h0, exp_addr(k)});
            if (k == 10) chk("rd_during_sweep", rd_dat_o, rd_old);
            if (ovr) begin
                if (k == 2) pps_i = 1'b0;
                if (k == 8) pps_i = 1'b1;
                clr_overrun_i = (k == 10);
            end else if (k == 15) begin
                pps_i = 1'b0;
            end
            if (k == rst_at) begin
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                chk_reset_outputs("midsweep_rst");
                return;
            end
            tick();
        end
        chk("final_capture_busy", {31'h0, busy_o}, 32'h1);
        chk("final_capture_addr", {26'h0, scal_addr_o}, 32'h0);
        chk("done_before_swap", {31'h0, snap_done_o}, 32'h0);
        tick();
        chk("swap_busy", {31'h0, busy_o}, 32'h0);
        chk("swap_done", {31'h0, snap_done_o}, 32'h1);
        chk("rd_before_swap", rd_dat_o, rd_old);
        tick();
        chk("done_pulse_end", {31'h0, snap_done_o}, 32'h0);
        chk("valid_after_swap", {31'h0, snap_valid_o}, 32'h1);
        chk("snap_count", {16'h0, snap_count_o}, {16'h0, cnt_exp});
        chk("rd_issued_in_swap", rd_dat_o, rd_old);
        chk("overrun", {31'h0, overrun_o}, {31'h0, ovr_exp});
        tick();
        chk("rd_after_swap", rd_dat_o, b | 32'h5);
    endtask

    task automatic readback(input logic [31:0] b);
        for (int i = 0; i < 36; i++) begin
            rd_addr_i = 6'(i);
            tick();
            chk("readback", rd_dat_o, b | {26'h0, exp_addr(i)});
        end
        rd_addr_i = 6'd36;
        tick();
        chk("rd_addr_36", rd_dat_o, 32'h0);
        rd_addr_i = 6'd63;
        tick();
        chk("rd_addr_63", rd_dat_o, 32'h0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_i = 1'b1; pps_i = 1'b0; rd_addr_i = 6'd0; clr_overrun_i = 1'b0; base = 32'h0;
        tick(); tick(); tick();
        chk_reset_outputs("reset");
        rst_i = 1'b0;
        rd_addr_i = 6'd5;
        tick();
        chk("rd_before_valid", rd_dat_o, 32'h0);

        // First snapshot, followed by a full readback.
        do_snap(32'h0000_0000, 32'h0, 16'd1, 1'b0, -1, 1'b0);
        readback(32'h0000_0000);

        // Second snapshot with new model data. The old bank stays visible until the swap.
        do_snap(32'hA500_0000, 32'h0000_0005, 16'd2, 1'b0, -1, 1'b0);
        readback(32'hA500_0000);

        // PPS edge at sweep index 10, with a coincident overrun clear.
        do_snap(32'h5A00_0000, 32'hA500_0005, 16'd3, 1'b1, -1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_retrigger", {31'h0, busy_o}, 32'h0);
        end
        chk("count_after_overrun", {16'h0, snap_count_o}, 32'd3);
        pps_i = 1'b0; clr_overrun_i = 1'b1;
        tick();
        clr_overrun_i = 1'b0;
        chk("overrun_cleared", {31'h0, overrun_o}, 32'h0);
        tick(); tick();

        // Reset at sweep index 20, then a clean snapshot.
        do_snap(32'hC300_0000, 32'h5A00_0005, 16'd0, 1'b0, 20, 1'b0);
        do_snap(32'h1100_0000, 32'h0, 16'd1, 1'b0, -1, 1'b0);
        readback(32'h1100_0000);

        // Preload the counter just below wrap.
        force dut.snap_count_d = 16'hFFFF;
        tick();
        release dut.snap_count_d;
        chk("count_preload", {16'h0, snap_count_o}, 32'h0000_FFFF);
        do_snap(32'h2200_0000, 32'h1100_0005, 16'h0000, 1'b0, -1, 1'b0);
        readback(32'h2200_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
